ir_err_compute: RTL and testbench



---
 rtl/ir_err_compute.sv | 156 +++++++++++++++
 tb/tb_ir_err_compute.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ir_err_compute.sv
// ir_err_compute
// Sequences the eight IR line sensors through the shared A2D one frame at a
// time. Each frame forms a signed, position-weighted sum of the readings,
// scales it down by an arithmetic shift and saturates it to 11 bits for the
// steering PID.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   go           run enable; frames are taken only while high
//   cnv_cmplt    A2D conversion done (one-cycle pulse)
//   res          A2D result, unsigned, valid with cnv_cmplt
//   strt_cnv     one-cycle pulse starting an A2D conversion
//   chnnl        A2D channel select, stable from strt_cnv until cnv_cmplt
//   IR_en        IR emitter enable
//   err_sat      signed saturated error
//   err_vld      one-cycle strobe: err_sat/line_present just updated
//   line_present some channel >= LINE_THRES in the last completed frame
module ir_err_compute #(
   parameter int unsigned SETTLE_CYCLES = 4096,
   parameter logic [11:0] LINE_THRES    = 12'h080,
   parameter int unsigned ERR_SHIFT     = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               go,
   input  logic               cnv_cmplt,
   input  logic [11:0]        res,
   output logic               strt_cnv,
   output logic [2:0]         chnnl,
   output logic               IR_en,
   output logic signed [10:0] err_sat,
   output logic               err_vld,
   output logic               line_present
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SETTLE = 3'd1;
   localparam logic [2:0] CONV   = 3'd2;
   localparam logic [2:0] WAIT   = 3'd3;
   localparam logic [2:0] CALC   = 3'd4;

   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

   logic [2:0]         state;
   logic [15:0]        settle_cnt;
   logic signed [16:0] acc;
   logic               seen;

   // Weights are powers of two, so the product is a shift of the
   // zero-extended reading. Worst case magnitude 8*4095 fits in 17 bits.
   function automatic logic signed [16:0] weigh(input logic [2:0] ch,
                                                input logic [11:0] r);
      logic signed [16:0] mag;
      mag = $signed({5'b0, r});
      case (ch)
         3'd0:    weigh = -(mag <<< 3);
         3'd1:    weigh = -(mag <<< 2);
         3'd2:    weigh = -(mag <<< 1);
         3'd3:    weigh = -mag;
         3'd4:    weigh = mag;
         3'd5:    weigh = mag <<< 1;
         3'd6:    weigh = mag <<< 2;
         default: weigh = mag <<< 3;
      endcase
   endfunction

   // Arithmetic shift floors toward minus infinity, then clamp to 11 bits.
   function automatic logic signed [10:0] sat11(input logic signed [16:0] a);
      logic signed [16:0] t;
      t = a >>> ERR_SHIFT;
      if (t > 17'sd1023)
         sat11 = $signed(11'h3FF);
      else if (t < -17'sd1024)
         sat11 = $signed(11'h400);
      else
         sat11 = $signed(t[10:0]);
   endfunction

   // Emitter stays on through settle and all eight conversions; it drops
   // only in IDLE and for the single CALC cycle between frames.
   assign strt_cnv = (state == CONV);
   assign IR_en    = (state == SETTLE) || (state == CONV) || (state == WAIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         settle_cnt   <= '0;
         acc          <= '0;
         seen         <= 1'b0;
         chnnl        <= '0;
         err_sat      <= '0;
         err_vld      <= 1'b0;
         line_present <= 1'b0;
      end else begin
         err_vld <= 1'b0;
         // Dropping go abandons the frame outright, even over a
         // simultaneous cnv_cmplt; the published outputs are left alone.
         if ((state != IDLE) && !go) begin
            state <= IDLE;
            chnnl <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (go) begin
                     state      <= SETTLE;
                     settle_cnt <= '0;
                     acc        <= '0;
                     seen       <= 1'b0;
                  end
               end
               SETTLE: begin
                  if (settle_cnt == SETTLE_LAST) begin
                     state <= CONV;
                     chnnl <= '0;
                  end else begin
                     settle_cnt <= settle_cnt + 16'd1;
                  end
               end
               CONV: begin
                  state <= WAIT;
               end
               // Accumulate stage: one weighted reading per conversion
               WAIT: begin
                  if (cnv_cmplt) begin
                     acc <= acc + weigh(chnnl, res);
                     if (res >= LINE_THRES)
                        seen <= 1'b1;
                     if (chnnl == 3'd7) begin
                        state <= CALC;
                     end else begin
                        chnnl <= chnnl + 3'd1;
                        state <= CONV;
                     end
                  end
               end
               // Output stage: publish the frame and restart settling
               CALC: begin
                  err_sat      <= sat11(acc);
                  line_present <= seen;
                  err_vld      <= 1'b1;
                  state        <= SETTLE;
                  settle_cnt   <= '0;
                  acc          <= '0;
                  seen         <= 1'b0;
                  chnnl        <= '0;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ir_err_compute.sv
module tb_ir_err_compute;

   logic               clk;
   logic               rst_n;
   logic               go;
   logic               cnv_cmplt;
   logic [11:0]        res;
   logic               strt_cnv;
   logic [2:0]         chnnl;
   logic               IR_en;
   logic signed [10:0] err_sat;
   logic               err_vld;
   logic               line_present;

   logic [11:0] vec [8];
   int          checks;
   int          failures;
   int          pend;

   ir_err_compute #(
      .SETTLE_CYCLES(4),
      .LINE_THRES   (12'h080),
      .ERR_SHIFT    (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .go          (go),
      .cnv_cmplt   (cnv_cmplt),
      .res         (res),
      .strt_cnv    (strt_cnv),
      .chnnl       (chnnl),
      .IR_en       (IR_en),
      .err_sat     (err_sat),
      .err_vld     (err_vld),
      .line_present(line_present)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // A2D model: cnv_cmplt pulses three cycles after the strt_cnv cycle and
   // returns the reading of the channel currently selected.
   initial begin
      pend      = 0;
      cnv_cmplt = 1'b0;
      res       = '0;
      forever begin
         @(negedge clk);
         cnv_cmplt = 1'b0;
         if (!rst_n) begin
            pend = 0;
         end else if (strt_cnv) begin
            pend = 3;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               cnv_cmplt = 1'b1;
               res       = vec[chnnl];
            end
         end
      end
   end

   task automatic set_vec(input logic [11:0] base, input int ch, input logic [11:0] val);
      for (int i = 0; i < 8; i++) vec[i] = base;
      if (ch >= 0) vec[ch] = val;
   endtask

   // Runs until err_vld, checking channel order, settle length (optional),
   // latency from the ch7 completion, the CALC gap in IR_en and the results.
   task automatic run_frame(input string tag, input int exp_err, input int exp_lp,
                            input bit chk_settle);
      int   k;
      int   c7;
      int   settle;
      bit   got;
      logic ir_prev;
      k = 0; c7 = -100; settle = 0; got = 1'b0; ir_prev = 1'b1;
      for (int cyc = 0; cyc < 300 && !got; cyc++) begin
         @(negedge clk); #1;
         if (err_vld) begin
            got = 1'b1;
            check({tag, "_err"}, int'(err_sat), exp_err);
            check({tag, "_lp"}, int'(line_present), exp_lp);
            check({tag, "_latency"}, cyc - c7, 2);
            check({tag, "_calc_ir_off"}, int'(ir_prev), 0);
            check({tag, "_nconv"}, k, 8);
         end else begin
            if (strt_cnv) begin
               if (chk_settle && k == 0) check({tag, "_settle_len"}, settle, 4);
               check({tag, "_chnnl_order"}, int'(chnnl), k);
               k++;
            end else if (IR_en) begin
               settle++;
            end else begin
               settle = 0;
            end
            if (cnv_cmplt && chnnl == 3'd7) c7 = cyc;
         end
         ir_prev = IR_en;
      end
      if (!got) check({tag, "_timeout"}, 0, 1);
      @(negedge clk); #1;
      check({tag, "_vld_pulse"}, int'(err_vld), 0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      go       = 1'b0;
      set_vec(12'h100, -1, 12'h000);
      repeat (3) @(negedge clk);
      #1;
      check("rst_strt", int'(strt_cnv), 0);
      check("rst_chnnl", int'(chnnl), 0);
      check("rst_ir", int'(IR_en), 0);
      check("rst_err", int'(err_sat), 0);
      check("rst_vld", int'(err_vld), 0);
      check("rst_lp", int'(line_present), 0);
      rst_n = 1'b1;
      @(negedge clk); #1;
      check("idle_ir", int'(IR_en), 0);

      go = 1'b1;
      run_frame("flat", 0, 1, 1'b1);
      set_vec(12'h000, 7, 12'hFFF);
      run_frame("ch7_max", 1023, 1, 1'b0);
      set_vec(12'h000, 0, 12'hFFF);
      run_frame("ch0_max", -1024, 1, 1'b0);
      set_vec(12'h000, 4, 12'h080);
      run_frame("ch4_thr", 16, 1, 1'b0);
      set_vec(12'h000, 3, 12'h010);
      run_frame("ch3_neg", -2, 0, 1'b0);

      // Drop go in the same cycle as the ch5 completion
      set_vec(12'h100, -1, 12'h000);
      begin
         bit hit;
         hit = 1'b0;
         for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk); #1;
            if (cnv_cmplt && chnnl == 3'd5) begin
               go  = 1'b0;
               hit = 1'b1;
            end
         end
         if (!hit) check("drop_timeout", 0, 1);
      end
      @(negedge clk); #1;
      check("drop_ir", int'(IR_en), 0);
      check("drop_chnnl", int'(chnnl), 0);
      begin
         int vld_seen;
         vld_seen = 0;
         for (int i = 0; i < 20; i++) begin
            if (err_vld) vld_seen++;
            @(negedge clk); #1;
         end
         check("drop_no_vld", vld_seen, 0);
      end
      check("drop_err_hold", int'(err_sat), -2);
      check("drop_lp_hold", int'(line_present), 0);
      check("drop_strt", int'(strt_cnv), 0);

      set_vec(12'h000, 4, 12'h080);
      go = 1'b1;
      run_frame("restart", 16, 1, 1'b1);

      // Asynchronous reset while waiting on ch2
      set_vec(12'h100, -1, 12'h000);
      begin
         bit hit;
         hit = 1'b0;
         for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk); #1;
            if (strt_cnv && chnnl == 3'd2) hit = 1'b1;
         end
         if (!hit) check("rst2_timeout", 0, 1);
      end
      @(negedge clk); #1;
      check("pre_rst_ir", int'(IR_en), 1);
      rst_n = 1'b0;
      #1;
      check("arst_ir", int'(IR_en), 0);
      check("arst_chnnl", int'(chnnl), 0);
      check("arst_err", int'(err_sat), 0);
      check("arst_lp", int'(line_present), 0);
      check("arst_vld", int'(err_vld), 0);
      check("arst_strt", int'(strt_cnv), 0);
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      run_frame("post_rst", 0, 1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
